bootrom_arbiter: RTL and testbench
==================================

BOOTROM_ARBITER -- requirements
Module: bootrom_arbiter

Interface
REQ-001 SHALL have parameter LAST_ADDR, default 4'hB, highest implemented ROM word address.
REQ-002 SHALL have parameter PATCH_BASE, default 4'h8, lowest writable (patch) ROM word address.
REQ-003 SHALL have ports:
- romclk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req, cpu_we  in  1  CPU request / write select.
- cpu_addr  in  4  CPU word address.
- cpu_wdata  in  16  CPU write data.
- cpu_ack, cpu_err  out  1  CPU completion pulse / error flag.
- cpu_rdata  out  16  CPU read data.
- spi_req, spi_we, spi_addr[3:0], spi_wdata[15:0]  in  SPI-loader request, same meaning as cpu_*.
- spi_ack, spi_err  out  1  SPI completion pulse / error flag.
- spi_rdata  out  16  SPI read data.
- cpu_lock  in  1  single-cycle pulse that sets the patch lock.
- rom_cs, rom_we  out  1  ROM chip select / write enable.
- rom_addr  out  4  ROM word address.
- rom_din  out  16  ROM write data.
- rom_dout  in  16  ROM read data.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-004 SHALL implement FSM states IDLE, ACCESS, RESP; all outputs registered on posedge romclk.
REQ-005 Requests are level-held; requester keeps req/we/addr/wdata stable until its ack and drops req the cycle after ack.
REQ-006 IDLE: if any req is high, SHALL grant one requester and latch its we/addr/wdata; with no req, SHALL stay in IDLE.
REQ-007 Arbitration round-robin: with both req high, grant the requester not served last; single req is granted directly; last-served register resets to SPI so CPU wins the first tie.
REQ-008 Legal request: IDLE -> ACCESS; during ACCESS exactly one cycle: rom_cs=1, rom_we=latched we, rom_addr/rom_din=latched values.
REQ-009 ACCESS -> RESP: rom_cs=0, rom_we=0; granted ack=1 for exactly one cycle; for reads, granted rdata SHALL be loaded with rom_dout as sampled at the end of ACCESS.
REQ-010 RESP -> IDLE unconditionally; legal-request latency req sampled edge N -> ack high cycle N+2.
REQ-011 Illegal request SHALL go IDLE -> RESP with ack=1 and err=1, rom_cs never asserted (latency 1 cycle); illegal = addr > LAST_ADDR; or write with addr < PATCH_BASE; or write while lock=1.
REQ-012 err SHALL be 0 on every legal ack and 0 whenever ack is 0.
REQ-013 rdata of each port SHALL hold its value except on that port's legal read ack; writes and errors leave rdata unchanged.
REQ-014 Ungranted requester's ack/err/rdata SHALL be unaffected; a request arriving during ACCESS/RESP waits in IDLE arbitration.
REQ-015 cpu_lock=1 on any edge SHALL set lock; lock cleared only by rst; lock set during a granted write's ACCESS does not abort that write.
REQ-016 rom_addr/rom_din SHALL hold their last values outside ACCESS; rom_we SHALL never be 1 while rom_cs is 0.

Reset
REQ-017 rst=1 SHALL immediately force: state IDLE, rom_cs=0, rom_we=0, rom_addr=0, rom_din=0, cpu_ack=spi_ack=0, cpu_err=spi_err=0, cpu_rdata=spi_rdata=0, busy=0, lock=0, last-served=SPI.
REQ-018 rst during ACCESS or RESP SHALL abort the transaction with no ack issued after rst release; pending req re-arbitrates from IDLE.

Verification
REQ-019 After rst, CPU read addr 3 -> rom_cs high one cycle, cpu_ack on cycle N+2, cpu_rdata=16'h1007, cpu_err=0.
REQ-020 Same-cycle CPU read addr 0 and SPI write addr 9 data 16'hABCD -> CPU acked first with cpu_rdata=16'hF200, then SPI one ACCESS with rom_we=1, rom_addr=9, rom_din=16'hABCD; subsequent CPU read addr 9 -> 16'hABCD.
REQ-021 SPI write addr 2 -> spi_ack=1, spi_err=1 on cycle N+1, rom_cs stays 0; CPU read addr 4'hC -> cpu_err=1, rom_cs stays 0.
REQ-022 cpu_lock pulse then SPI write addr 8 -> spi_err=1, word 8 unchanged; SPI read addr 8 -> legal, spi_err=0.
REQ-023 Both req held continuously for 6 transactions -> grants alternate CPU, SPI, CPU, SPI, CPU, SPI; busy low exactly one cycle between transactions.
REQ-024 rst asserted mid-ACCESS -> rom_cs/rom_we drop asynchronously, no ack; after release with req still high, transaction reruns and completes normally.

Source files
------------

// File: rtl/bootrom_arbiter.sv
// Boot ROM arbiter: round-robin shares one ROM port between the CPU and the SPI loader.
// Writes are confined to the patch window [PATCH_BASE, LAST_ADDR] until the patch lock is set.
module bootrom_arbiter #(
    parameter logic [3:0] LAST_ADDR  = 4'hB,
    parameter logic [3:0] PATCH_BASE = 4'h8
) (
    input  logic        romclk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [15:0] cpu_rdata,
    input  logic        spi_req,
    input  logic        spi_we,
    input  logic [3:0]  spi_addr,
    input  logic [15:0] spi_wdata,
    output logic        spi_ack,
    output logic        spi_err,
    output logic [15:0] spi_rdata,
    input  logic        cpu_lock,
    output logic        rom_cs,
    output logic        rom_we,
    output logic [3:0]  rom_addr,
    output logic [15:0] rom_din,
    input  logic [15:0] rom_dout,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      r_state;
    logic        r_last_spi;
    logic        r_lock;
    logic        r_gnt_spi;
    logic        r_rom_cs;
    logic        r_rom_we;
    logic [3:0]  r_rom_addr;
    logic [15:0] r_rom_din;
    logic        r_cpu_ack;
    logic        r_cpu_err;
    logic [15:0] r_cpu_rdata;
    logic        r_spi_ack;
    logic        r_spi_err;
    logic [15:0] r_spi_rdata;
    logic        r_busy;

    logic        w_any_req;
    logic        w_gnt_spi;
    logic        w_we;
    logic [3:0]  w_addr;
    logic [15:0] w_wdata;
    logic        w_illegal;

    // SPI wins only when alone or when the CPU was served last.
    assign w_any_req = cpu_req | spi_req;
    assign w_gnt_spi = spi_req & (~cpu_req | ~r_last_spi);
    assign w_we      = w_gnt_spi ? spi_we    : cpu_we;
    assign w_addr    = w_gnt_spi ? spi_addr  : cpu_addr;
    assign w_wdata   = w_gnt_spi ? spi_wdata : cpu_wdata;
    assign w_illegal = (w_addr > LAST_ADDR) | (w_we & ((w_addr < PATCH_BASE) | r_lock));

    always_ff @(posedge romclk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_last_spi  <= 1'b1;
            r_lock      <= 1'b0;
            r_gnt_spi   <= 1'b0;
            r_rom_cs    <= 1'b0;
            r_rom_we    <= 1'b0;
            r_rom_addr  <= '0;
            r_rom_din   <= '0;
            r_cpu_ack   <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_cpu_rdata <= '0;
            r_spi_ack   <= 1'b0;
            r_spi_err   <= 1'b0;
            r_spi_rdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_lock <= r_lock | cpu_lock;
            unique case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_gnt_spi  <= w_gnt_spi;
                        r_last_spi <= w_gnt_spi;
                        r_busy     <= 1'b1;
                        if (w_illegal) begin
                            // Rejected without touching the ROM; respond next cycle.
                            r_state <= StResp;
                            if (w_gnt_spi) begin
                                r_spi_ack <= 1'b1;
                                r_spi_err <= 1'b1;
                            end else begin
                                r_cpu_ack <= 1'b1;
                                r_cpu_err <= 1'b1;
                            end
                        end else begin
                            r_state    <= StAccess;
                            r_rom_cs   <= 1'b1;
                            r_rom_we   <= w_we;
                            r_rom_addr <= w_addr;
                            r_rom_din  <= w_wdata;
                        end
                    end
                end
                StAccess: begin
                    r_state  <= StResp;
                    r_rom_cs <= 1'b0;
                    r_rom_we <= 1'b0;
                    if (r_gnt_spi) begin
                        r_spi_ack <= 1'b1;
                        if (!r_rom_we) r_spi_rdata <= rom_dout;
                    end else begin
                        r_cpu_ack <= 1'b1;
                        if (!r_rom_we) r_cpu_rdata <= rom_dout;
                    end
                end
                StResp: begin
                    r_state   <= StIdle;
                    r_busy    <= 1'b0;
                    r_cpu_ack <= 1'b0;
                    r_cpu_err <= 1'b0;
                    r_spi_ack <= 1'b0;
                    r_spi_err <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign cpu_err   = r_cpu_err;
    assign cpu_rdata = r_cpu_rdata;
    assign spi_ack   = r_spi_ack;
    assign spi_err   = r_spi_err;
    assign spi_rdata = r_spi_rdata;
    assign rom_cs    = r_rom_cs;
    assign rom_we    = r_rom_we;
    assign rom_addr  = r_rom_addr;
    assign rom_din   = r_rom_din;
    assign busy      = r_busy;

endmodule

// File: tb/tb_bootrom_arbiter.sv
// Bench for bootrom_arbiter: vector table plus hand sequences, with a per-port scoreboard
// fed at request time and drained on each ack. ROM word i starts as 16'h1001 + 2*i (word 0 = F200).
module tb_bootrom_arbiter;

    logic        romclk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [3:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_ack, cpu_err;
    logic [15:0] cpu_rdata;
    logic        spi_req = 1'b0, spi_we = 1'b0;
    logic [3:0]  spi_addr = '0;
    logic [15:0] spi_wdata = '0;
    logic        spi_ack, spi_err;
    logic [15:0] spi_rdata;
    logic        cpu_lock = 1'b0;
    logic        rom_cs, rom_we;
    logic [3:0]  rom_addr;
    logic [15:0] rom_din;
    logic [15:0] rom_dout;
    logic        busy;

    bootrom_arbiter dut (
        .romclk    (romclk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .spi_req   (spi_req),
        .spi_we    (spi_we),
        .spi_addr  (spi_addr),
        .spi_wdata (spi_wdata),
        .spi_ack   (spi_ack),
        .spi_err   (spi_err),
        .spi_rdata (spi_rdata),
        .cpu_lock  (cpu_lock),
        .rom_cs    (rom_cs),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_din   (rom_din),
        .rom_dout  (rom_dout),
        .busy      (busy)
    );

    always #5 romclk = ~romclk;

    // Asynchronous-read, synchronous-write ROM/patch RAM.
    logic [15:0] mem [16];
    assign rom_dout = mem[rom_addr];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h1001 + 16'(2 * i);
        mem[0] = 16'hF200;
        forever begin
            @(posedge romclk);
            if (rom_cs && rom_we) mem[rom_addr] <= rom_din;
        end
    end

    typedef struct {
        bit          spi;
        bit          we;
        logic [3:0]  addr;
        logic [15:0] wdata;
        bit          err;
        logic [15:0] rdata;
        int          lat;
        int          cs;
    } vec_t;

    typedef struct {
        bit          we;
        bit          err;
        logic [15:0] rdata;
        int          issue;
        int          lat;
    } exp_t;

    exp_t        cpu_q[$];
    exp_t        spi_q[$];
    bit          ack_order[$];
    int          gaps[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          n_cs = 0;
    int          busy_run = 0;
    bit          gap_en = 1'b0;
    logic [15:0] last_rd_cpu = '0;
    logic [15:0] last_rd_spi = '0;
    logic        last_cs_we = 1'b0;
    logic [3:0]  last_cs_addr = '0;
    logic [15:0] last_cs_din = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name, input string what);
        checks++;
        failures++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic take_ack(input bit spi);
        exp_t        e;
        logic [15:0] rd;
        logic        er;
        rd = spi ? spi_rdata : cpu_rdata;
        er = spi ? spi_err : cpu_err;
        ack_order.push_back(spi);
        if (spi ? (spi_q.size() == 0) : (cpu_q.size() == 0)) begin
            fail_event(spi ? "spi_unexpected_ack" : "cpu_unexpected_ack", "got ack, expected none");
            return;
        end
        e = spi ? spi_q.pop_front() : cpu_q.pop_front();
        chk(spi ? "spi_err" : "cpu_err", 32'(er), 32'(e.err));
        if (!e.err && !e.we) begin
            chk(spi ? "spi_rdata" : "cpu_rdata", 32'(rd), 32'(e.rdata));
            if (spi) last_rd_spi = e.rdata;
            else last_rd_cpu = e.rdata;
        end
        if (e.lat != 0) chk(spi ? "spi_latency" : "cpu_latency", 32'(cyc - e.issue), 32'(e.lat));
    endtask

    initial forever begin
        @(posedge romclk);
        cyc++;
    end

    // Monitor: drains the scoreboard on acks and checks per-cycle invariants.
    initial forever begin
        @(negedge romclk);
        if (rst) begin
            last_rd_cpu = '0;
            last_rd_spi = '0;
        end else begin
            if (rom_cs) begin
                n_cs++;
                last_cs_we   = rom_we;
                last_cs_addr = rom_addr;
                last_cs_din  = rom_din;
            end
            if (busy) begin
                if (gap_en && busy_run != 0) gaps.push_back(busy_run);
                busy_run = 0;
            end else begin
                busy_run++;
            end
            if (cpu_ack) take_ack(1'b0);
            if (spi_ack) take_ack(1'b1);
            chk("cpu_rdata_hold", 32'(cpu_rdata), 32'(last_rd_cpu));
            chk("spi_rdata_hold", 32'(spi_rdata), 32'(last_rd_spi));
            chk("cpu_err_without_ack", 32'(cpu_err & ~cpu_ack), 32'd0);
            chk("spi_err_without_ack", 32'(spi_err & ~spi_ack), 32'd0);
            chk("rom_we_without_cs", 32'(rom_we & ~rom_cs), 32'd0);
            chk("dual_ack", 32'(cpu_ack & spi_ack), 32'd0);
        end
    end

    task automatic issue(input vec_t v);
        exp_t e;
        int   n;
        bit   got;
        e.we    = v.we;
        e.err   = v.err;
        e.rdata = v.rdata;
        e.issue = cyc;
        e.lat   = v.lat;
        if (v.spi) begin
            spi_q.push_back(e);
            spi_we = v.we; spi_addr = v.addr; spi_wdata = v.wdata; spi_req = 1'b1;
        end else begin
            cpu_q.push_back(e);
            cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_req = 1'b1;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            @(negedge romclk);
            n++;
            got = v.spi ? spi_ack : cpu_ack;
        end
        if (!got) fail_event(v.spi ? "spi_ack_timeout" : "cpu_ack_timeout", "no ack in 30 cycles");
        if (v.spi) spi_req = 1'b0;
        else cpu_req = 1'b0;
    endtask

    task automatic wait_cs(input string name);
        int n;
        n = 0;
        while (!rom_cs && n < 10) begin
            @(negedge romclk);
            n++;
        end
        chk(name, 32'(rom_cs), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        vec_t v;
        int   cs0;
        int   n;
        bit   exp_order[6];

        //           spi we addr   wdata     err rdata     lat cs
        vecs[0]  = '{0, 0, 4'h3, 16'h0000, 0, 16'h1007, 2, 1};
        vecs[1]  = '{1, 1, 4'h2, 16'h1234, 1, 16'h0000, 1, 0};
        vecs[2]  = '{0, 0, 4'hC, 16'h0000, 1, 16'h0000, 1, 0};
        vecs[3]  = '{1, 0, 4'hB, 16'h0000, 0, 16'h1017, 2, 1};
        vecs[4]  = '{0, 1, 4'h8, 16'h5A5A, 0, 16'h0000, 2, 1};
        vecs[5]  = '{1, 0, 4'h8, 16'h0000, 0, 16'h5A5A, 2, 1};
        vecs[6]  = '{0, 1, 4'hF, 16'h1111, 1, 16'h0000, 1, 0};
        vecs[7]  = '{0, 0, 4'h2, 16'h0000, 0, 16'h1005, 2, 1};
        vecs[8]  = '{1, 1, 4'h7, 16'h2222, 1, 16'h0000, 1, 0};
        vecs[9]  = '{0, 1, 4'hB, 16'h0BEE, 0, 16'h0000, 2, 1};
        vecs[10] = '{1, 0, 4'hB, 16'h0000, 0, 16'h0BEE, 2, 1};

        repeat (3) @(negedge romclk);
        chk("rst_rom_cs", 32'(rom_cs), 32'd0);
        chk("rst_rom_we", 32'(rom_we), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_rom_din", 32'(rom_din), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_spi_ack", 32'(spi_ack), 32'd0);
        chk("rst_cpu_err", 32'(cpu_err), 32'd0);
        chk("rst_spi_err", 32'(spi_err), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_spi_rdata", 32'(spi_rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge romclk);

        for (int i = 0; i < 11; i++) begin
            cs0 = n_cs;
            issue(vecs[i]);
            chk($sformatf("vec%0d_cs_cycles", i), 32'(n_cs - cs0), 32'(vecs[i].cs));
            @(negedge romclk);
        end

        // Simultaneous CPU read and SPI write: CPU first, then one SPI write access.
        ack_order.delete();
        fork
            begin
                v = '{0, 0, 4'h0, 16'h0000, 0, 16'hF200, 2, 1};
                issue(v);
            end
            begin
                vec_t vs;
                vs = '{1, 1, 4'h9, 16'hABCD, 0, 16'h0000, 0, 1};
                issue(vs);
            end
        join
        chk("tie_order_len", 32'(ack_order.size()), 32'd2);
        if (ack_order.size() == 2) begin
            chk("tie_first_cpu", 32'(ack_order[0]), 32'd0);
            chk("tie_second_spi", 32'(ack_order[1]), 32'd1);
        end
        chk("spi_wr_rom_we", 32'(last_cs_we), 32'd1);
        chk("spi_wr_rom_addr", 32'(last_cs_addr), 32'h9);
        chk("spi_wr_rom_din", 32'(last_cs_din), 32'hABCD);
        @(negedge romclk);
        v = '{0, 0, 4'h9, 16'h0000, 0, 16'hABCD, 2, 1};
        issue(v);
        @(negedge romclk);

        // Patch lock blocks writes but not reads.
        cpu_lock = 1'b1;
        @(negedge romclk);
        cpu_lock = 1'b0;
        v = '{0, 1, 4'hA, 16'h3333, 1, 16'h0000, 1, 0};
        issue(v);
        @(negedge romclk);
        v = '{1, 1, 4'h8, 16'h7777, 1, 16'h0000, 1, 0};
        issue(v);
        @(negedge romclk);
        v = '{1, 0, 4'h8, 16'h0000, 0, 16'h5A5A, 2, 1};
        issue(v);
        @(negedge romclk);

        // Both requesters held for three transactions each.
        ack_order.delete();
        gaps.delete();
        gap_en = 1'b1;
        fork
            begin
                vec_t vc;
                for (int k = 0; k < 3; k++) begin
                    vc = '{0, 0, 4'(k), 16'h0000, 0, (k == 0) ? 16'hF200 : 16'(16'h1001 + 2 * k),
                           0, 1};
                    issue(vc);
                end
            end
            begin
                vec_t vs;
                for (int k = 3; k < 6; k++) begin
                    vs = '{1, 0, 4'(k), 16'h0000, 0, 16'(16'h1001 + 2 * k), 0, 1};
                    issue(vs);
                end
            end
        join
        gap_en = 1'b0;
        exp_order = '{0, 1, 0, 1, 0, 1};
        chk("rr_order_len", 32'(ack_order.size()), 32'd6);
        for (int k = 0; k < 6 && k < ack_order.size(); k++)
            chk($sformatf("rr_grant%0d", k), 32'(ack_order[k]), 32'(exp_order[k]));
        chk("rr_gap_count", 32'(gaps.size()), 32'd6);
        for (int k = 1; k < 6 && k < gaps.size(); k++)
            chk($sformatf("rr_busy_gap%0d", k), 32'(gaps[k]), 32'd1);
        @(negedge romclk);

        // Reset in the middle of ACCESS aborts; the held request reruns afterwards.
        begin
            exp_t e;
            e = '{0, 0, 16'h1009, 0, 0};
            cpu_q.push_back(e);
        end
        cpu_we = 1'b0; cpu_addr = 4'h4; cpu_req = 1'b1;
        wait_cs("abort_cs_seen");
        #2 rst = 1'b1;
        #1;
        chk("abort_rom_cs", 32'(rom_cs), 32'd0);
        chk("abort_rom_we", 32'(rom_we), 32'd0);
        chk("abort_rom_addr", 32'(rom_addr), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cpu_ack", 32'(cpu_ack), 32'd0);
        repeat (2) @(negedge romclk);
        #2 rst = 1'b0;
        n = 0;
        while (!cpu_ack && n < 10) begin
            @(negedge romclk);
            n++;
        end
        chk("rerun_latency", 32'(n), 32'd2);
        cpu_req = 1'b0;
        @(negedge romclk);

        // Lock cleared by reset; a lock raised during a write's ACCESS does not abort it.
        fork
            begin
                vec_t vw;
                vw = '{0, 1, 4'h8, 16'h4444, 0, 16'h0000, 2, 1};
                issue(vw);
            end
            begin
                wait_cs("lock_wr_cs_seen");
                cpu_lock = 1'b1;
                @(negedge romclk);
                cpu_lock = 1'b0;
            end
        join
        @(negedge romclk);
        v = '{1, 0, 4'h8, 16'h0000, 0, 16'h4444, 2, 1};
        issue(v);
        @(negedge romclk);
        v = '{1, 1, 4'h9, 16'h0001, 1, 16'h0000, 1, 0};
        issue(v);
        repeat (2) @(negedge romclk);

        chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        chk("spi_q_drained", 32'(spi_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
